// File: rtl/dmem_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_if
//  Brief    : SRAM-like data-memory request/response bundle
//             (req/addr_ok/data_ok handshake with store fields and load data).
//  Revision : 1.0 - initial release
// ============================================================================
interface dmem_if;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  // Side that issues requests (a requester, or the arbiter towards memory)
  modport master (
    output req, addr, we, size, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  // Side that accepts requests (memory, or the arbiter towards a requester)
  modport slave (
    input  req, addr, we, size, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Brief    : Two-requester round-robin arbiter for one SRAM-like data-memory
//             port. A grant is held until its address handshake completes and
//             an order FIFO steers each in-order response back to its issuer.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic   clk,
  input  logic   resetn,
  dmem_if.slave  s0,
  dmem_if.slave  s1,
  dmem_if.master m,
  output logic   busy,
  output logic   err_spurious
);

  localparam int c_PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [0:0] {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

  lock_state_t        r_state;
  lock_state_t        w_state_nxt;
  logic               r_grant_q;
  logic               r_last_grant;
  logic               r_err;
  logic [c_CNT_W-1:0] r_count;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic               r_id_fifo [MAX_OUTSTANDING];

  logic w_grant;
  logic w_sel_req;
  logic w_full;
  logic w_issue;
  logic w_push;
  logic w_pop;
  logic w_nonempty;
  logic w_head;

  // Grant selection: a locked grant wins, otherwise alternate on contention
  always_comb begin
    w_grant = r_last_grant;
    if (r_state == ST_LOCKED) begin
      w_grant = r_grant_q;
    end else if (s0.req && s1.req) begin
      w_grant = ~r_last_grant;
    end else if (s0.req) begin
      w_grant = 1'b0;
    end else if (s1.req) begin
      w_grant = 1'b1;
    end
  end

  // A full order FIFO blocks issue; a same-cycle pop is deliberately not
  // allowed to free a slot so data_ok never reaches m.req combinationally.
  assign w_sel_req  = w_grant ? s1.req : s0.req;
  assign w_full     = (r_count == c_FULL);
  assign w_issue    = resetn && w_sel_req && !w_full;
  assign w_push     = w_issue && m.addr_ok;
  assign w_nonempty = (r_count != '0);
  assign w_pop      = resetn && m.data_ok && w_nonempty;
  assign w_head     = r_id_fifo[r_rd_ptr];

  // Downstream request fields follow the granted requester; forced low in reset
  assign m.req   = w_issue;
  assign m.addr  = !resetn ? '0 : (w_grant ? s1.addr  : s0.addr);
  assign m.we    = !resetn ? '0 : (w_grant ? s1.we    : s0.we);
  assign m.size  = !resetn ? '0 : (w_grant ? s1.size  : s0.size);
  assign m.wstrb = !resetn ? '0 : (w_grant ? s1.wstrb : s0.wstrb);
  assign m.wdata = !resetn ? '0 : (w_grant ? s1.wdata : s0.wdata);

  // Address handshake and response routing back to the requesters
  assign s0.addr_ok = w_push && !w_grant;
  assign s1.addr_ok = w_push &&  w_grant;
  assign s0.data_ok = w_pop && !w_head;
  assign s1.data_ok = w_pop &&  w_head;
  assign s0.rdata   = (w_pop && !w_head) ? m.rdata : '0;
  assign s1.rdata   = (w_pop &&  w_head) ? m.rdata : '0;

  assign busy         = w_nonempty;
  assign err_spurious = r_err;

  // Lock state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_OPEN;
    else         r_state <= w_state_nxt;
  end

  // Lock next state: stay locked only while a request waits for addr_ok;
  // a cancelled locked request simply falls back to open.
  always_comb begin
    w_state_nxt = ST_OPEN;
    if (w_issue && !m.addr_ok) w_state_nxt = ST_LOCKED;
  end

  // Held grant and round-robin history
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_grant_q    <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      if (w_issue && !m.addr_ok) r_grant_q    <= w_grant;
      if (w_push)                r_last_grant <= w_grant;
    end
  end

  // Order FIFO of requester IDs with occupancy count
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) r_id_fifo[i] <= 1'b0;
    end else begin
      if (w_push) begin
        r_id_fifo[r_wr_ptr] <= w_grant;
        r_wr_ptr            <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    end
  end

  // Sticky flag for a response arriving with nothing outstanding
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                       r_err <= 1'b0;
    else if (m.data_ok && !w_nonempty) r_err <= 1'b1;
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Brief    : Directed and randomized bench for dmem_arbiter with a queue-based
//             reference model of grant order and response routing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int c_MAX = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic busy;
  logic err_spurious;

  dmem_if s0_if ();
  dmem_if s1_if ();
  dmem_if m_if ();

  // Bench-side stimulus variables
  logic        t_req   [2];
  logic [31:0] t_addr  [2];
  logic        t_we    [2];
  logic [1:0]  t_size  [2];
  logic [3:0]  t_wstrb [2];
  logic [31:0] t_wdata [2];
  logic        t_maok;
  logic        t_mdok;
  logic [31:0] t_mrdata;

  assign s0_if.req   = t_req[0];
  assign s0_if.addr  = t_addr[0];
  assign s0_if.we    = t_we[0];
  assign s0_if.size  = t_size[0];
  assign s0_if.wstrb = t_wstrb[0];
  assign s0_if.wdata = t_wdata[0];
  assign s1_if.req   = t_req[1];
  assign s1_if.addr  = t_addr[1];
  assign s1_if.we    = t_we[1];
  assign s1_if.size  = t_size[1];
  assign s1_if.wstrb = t_wstrb[1];
  assign s1_if.wdata = t_wdata[1];
  assign m_if.addr_ok = t_maok;
  assign m_if.data_ok = t_mdok;
  assign m_if.rdata   = t_mrdata;

  dmem_arbiter #(.MAX_OUTSTANDING(c_MAX)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .s0           (s0_if),
    .s1           (s1_if),
    .m            (m_if),
    .busy         (busy),
    .err_spurious (err_spurious)
  );

  always #5 clk = ~clk;

  // Reference model: who was served last, who is holding the port, and the
  // queue of requesters waiting for their in-order responses.
  int  mdl_last;
  int  mdl_held;
  int  mdl_q[$];
  bit  mdl_err;
  bit  acc [2];
  int  n_pass  = 0;
  int  n_total = 0;
  int  cyc     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  task automatic model_reset();
    mdl_last = 1;
    mdl_held = -1;
    mdl_q.delete();
    mdl_err  = 1'b0;
  endtask

  // One clock: check combinational outputs mid-cycle, then advance the model
  task automatic tick(input string tag);
    int   g;
    bit   ereq, eacc, epop;
    int   head;
    logic [31:0] eaddr, ewdata;
    @(negedge clk);
    acc[0] = 1'b0;
    acc[1] = 1'b0;
    if (!resetn) begin
      model_reset();
      ereq = 0; eacc = 0; epop = 0; head = 0; eaddr = '0; ewdata = '0; g = 0;
    end else begin
      if (mdl_held >= 0)           g = mdl_held;
      else if (t_req[0] && t_req[1]) g = 1 - mdl_last;
      else if (t_req[0])           g = 0;
      else if (t_req[1])           g = 1;
      else                         g = mdl_last;
      ereq   = t_req[g] && (mdl_q.size() < c_MAX);
      eacc   = ereq && t_maok;
      epop   = t_mdok && (mdl_q.size() > 0);
      head   = (mdl_q.size() > 0) ? mdl_q[0] : 0;
      eaddr  = t_addr[g];
      ewdata = t_wdata[g];
    end
    chk({tag, "/m_req"},     m_if.req,      32'(ereq));
    chk({tag, "/m_addr"},    m_if.addr,     eaddr);
    chk({tag, "/m_wdata"},   m_if.wdata,    ewdata);
    chk({tag, "/s0_addr_ok"}, s0_if.addr_ok, 32'(eacc && g == 0));
    chk({tag, "/s1_addr_ok"}, s1_if.addr_ok, 32'(eacc && g == 1));
    chk({tag, "/s0_data_ok"}, s0_if.data_ok, 32'(epop && head == 0));
    chk({tag, "/s1_data_ok"}, s1_if.data_ok, 32'(epop && head == 1));
    chk({tag, "/s0_rdata"},  s0_if.rdata,   (epop && head == 0) ? t_mrdata : 32'h0);
    chk({tag, "/s1_rdata"},  s1_if.rdata,   (epop && head == 1) ? t_mrdata : 32'h0);
    chk({tag, "/busy"},      busy,          32'(mdl_q.size() != 0));
    chk({tag, "/err"},       err_spurious,  32'(mdl_err));
    @(posedge clk);
    if (!resetn) begin
      model_reset();
    end else begin
      if (t_mdok) begin
        if (mdl_q.size() > 0) void'(mdl_q.pop_front());
        else                  mdl_err = 1'b1;
      end
      mdl_held = (ereq && !t_maok) ? g : -1;
      if (eacc) begin
        mdl_last = g;
        mdl_q.push_back(g);
        acc[g] = 1'b1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic set_req(input int p, input logic [31:0] a, input logic we);
    t_req[p]   = 1'b1;
    t_addr[p]  = a;
    t_we[p]    = we;
    t_size[p]  = 2'd2;
    t_wstrb[p] = we ? 4'hF : 4'h0;
    t_wdata[p] = a ^ 32'hA5A5_0000;
  endtask

  task automatic drop(input int p);
    t_req[p] = 1'b0;
  endtask

  // Return every outstanding response, bounded by the FIFO depth
  task automatic drain(input string tag);
    t_maok = 1'b0;
    for (int i = 0; i < c_MAX + 2 && mdl_q.size() > 0; i++) begin
      t_mdok   = 1'b1;
      t_mrdata = $urandom;
      tick(tag);
    end
    t_mdok = 1'b0;
    chk({tag, "/drained"}, 32'(mdl_q.size()), 32'h0);
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      t_req[p] = 1'b0; t_addr[p] = '0; t_we[p] = 1'b0;
      t_size[p] = '0; t_wstrb[p] = '0; t_wdata[p] = '0;
    end
    t_maok = 1'b0; t_mdok = 1'b0; t_mrdata = '0;
    model_reset();

    // Reset state
    resetn = 1'b0;
    tick("reset");
    resetn = 1'b1;

    // Single load on port 0 with immediate address and next-cycle data
    set_req(0, 32'h0000_0100, 1'b0);
    t_maok = 1'b1;
    tick("single_c0");
    drop(0);
    t_maok = 1'b0; t_mdok = 1'b1; t_mrdata = 32'h1234_5678;
    tick("single_c1");
    t_mdok = 1'b0;
    tick("single_c2");

    // Both requesting for four cycles: alternating grants, returns in order
    set_req(0, 32'h0000_0200, 1'b1);
    set_req(1, 32'h0000_0300, 1'b0);
    t_maok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      t_mdok   = (i != 0);
      t_mrdata = 32'hC0DE_0000 + 32'(i);
      tick("rr");
    end
    drop(0); drop(1);
    drain("rr_drain");

    // Held grant while addr_ok is low, then the other port gets its turn
    set_req(1, 32'h0000_0400, 1'b0);
    t_maok = 1'b0;
    tick("lock_c0");
    set_req(0, 32'h0000_0500, 1'b0);
    tick("lock_c1");
    tick("lock_c2");
    t_maok = 1'b1;
    tick("lock_c3");
    chk("lock_s1_accepted", 32'(acc[1]), 32'h1);
    drop(1);
    tick("lock_c4");
    chk("lock_s0_accepted", 32'(acc[0]), 32'h1);
    drop(0);
    drain("lock_drain");

    // Fill the order FIFO; a pop only re-enables issue on the next cycle
    set_req(0, 32'h0000_0600, 1'b1);
    t_maok = 1'b1;
    for (int i = 0; i < 5; i++) tick("full");
    chk("full_count", 32'(mdl_q.size()), 32'd4);
    t_mdok = 1'b1; t_mrdata = 32'hFEED_0001;
    tick("full_pop");
    t_mdok = 1'b0;
    tick("full_reissue");
    chk("full_reissue_acc", 32'(acc[0]), 32'h1);
    drop(0);
    drain("full_drain");

    // Response with nothing outstanding sets the sticky error
    t_mdok = 1'b1; t_mrdata = 32'hDEAD_BEEF;
    tick("spur_c0");
    t_mdok = 1'b0;
    tick("spur_c1");
    tick("spur_c2");

    // Asynchronous reset with two transactions outstanding
    set_req(0, 32'h0000_0700, 1'b0);
    t_maok = 1'b1;
    tick("rst_fill0");
    tick("rst_fill1");
    set_req(1, 32'h0000_0800, 1'b0);
    t_maok = 1'b1;
    #2 resetn = 1'b0;
    #1;
    chk("rst_async_busy",  busy,          32'h0);
    chk("rst_async_mreq",  m_if.req,      32'h0);
    chk("rst_async_maddr", m_if.addr,     32'h0);
    chk("rst_async_err",   err_spurious,  32'h0);
    tick("rst_low0");
    tick("rst_low1");
    resetn = 1'b1;
    tick("rst_after");
    chk("rst_first_grant_s0", 32'(acc[0]), 32'h1);
    drop(0); drop(1);
    drain("rst_drain");

    // Randomized traffic with protocol-respecting requesters
    for (int n = 0; n < 2000; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (t_req[p] && acc[p]) t_req[p] = 1'b0;
        else if (t_req[p] && mdl_held == p && $urandom_range(0, 15) == 0) t_req[p] = 1'b0;
        if (!t_req[p] && $urandom_range(0, 1) == 1) begin
          t_req[p]   = 1'b1;
          t_addr[p]  = $urandom;
          t_we[p]    = 1'($urandom_range(0, 1));
          t_size[p]  = 2'($urandom_range(0, 2));
          t_wstrb[p] = 4'($urandom);
          t_wdata[p] = $urandom;
        end
      end
      t_maok   = ($urandom_range(0, 2) != 0);
      t_mdok   = (mdl_q.size() > 0) && ($urandom_range(0, 1) == 1);
      t_mrdata = $urandom;
      tick("rand");
    end
    drop(0); drop(1);
    drain("rand_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
